// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter sequencing one memory port.
// Each transaction takes one ACCESS cycle; responses are registered.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MEMORY_BYTES  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     a_request,
  input  logic                     a_write,
  input  logic                     a_select_byte,
  input  logic [ADDRESS_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0]    a_input_data,
  output logic                     a_ready,
  output logic                     a_response_valid,
  output logic                     a_error,
  output logic [DATA_WIDTH-1:0]    a_output_data,
  input  logic                     b_request,
  input  logic                     b_write,
  input  logic                     b_select_byte,
  input  logic [ADDRESS_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0]    b_input_data,
  output logic                     b_ready,
  output logic                     b_response_valid,
  output logic                     b_error,
  output logic [DATA_WIDTH-1:0]    b_output_data,
  output logic                     mem_write,
  output logic                     mem_select_byte,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_input_data,
  input  logic [DATA_WIDTH-1:0]    mem_output_data
);

  localparam logic [ADDRESS_WIDTH-1:0] LIMIT =
    ADDRESS_WIDTH'(MEMORY_BYTES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state;
  state_t state_next;

  logic                     last_b;
  logic                     grant_a;
  logic                     grant_b;
  logic                     own_b;
  logic                     lat_write;
  logic                     lat_sel;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_data;
  logic                     in_range;
  logic                     done_a;
  logic                     done_b;

  assign in_range = lat_addr < LIMIT;
  assign done_a   = (state == ACCESS) && !own_b;
  assign done_b   = (state == ACCESS) && own_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Ties go to whichever requester did not win last.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          grant_a = a_request && (!b_request || last_b);
          grant_b = b_request && (!a_request || !last_b);
        end
        if (grant_a || grant_b) state_next = ACCESS;
      end
      ACCESS: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_b    <= 1'b1;
      own_b     <= 1'b0;
      lat_write <= 1'b0;
      lat_sel   <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
    end else if (grant_a || grant_b) begin
      last_b    <= grant_b;
      own_b     <= grant_b;
      lat_write <= grant_b ? b_write : a_write;
      lat_sel   <= grant_b ? b_select_byte : a_select_byte;
      lat_addr  <= grant_b ? b_address : a_address;
      lat_data  <= grant_b ? b_input_data : a_input_data;
    end
  end

  // Write strobe only exists in ACCESS; reset kills it at once.
  assign mem_write       = (state == ACCESS) && lat_write && in_range;
  assign mem_select_byte = lat_sel;
  assign mem_address     = lat_addr;
  assign mem_input_data  = lat_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_response_valid <= 1'b0;
      a_error          <= 1'b0;
      a_output_data    <= '0;
      b_response_valid <= 1'b0;
      b_error          <= 1'b0;
      b_output_data    <= '0;
    end else begin
      a_response_valid <= done_a;
      a_error          <= done_a && !in_range;
      b_response_valid <= done_b;
      b_error          <= done_b && !in_range;
      if (done_a && !lat_write && in_range)
        a_output_data <= mem_output_data;
      if (done_b && !lat_write && in_range)
        b_output_data <= mem_output_data;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: memory stub, cycle model, scoreboard.
// Directed scenarios followed by a randomized two-requester phase.
module tb_memory_arbiter;

  localparam int MB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_request = 1'b0;
  logic        a_write = 1'b0;
  logic        a_select_byte = 1'b0;
  logic [15:0] a_address = '0;
  logic [15:0] a_input_data = '0;
  logic        a_ready;
  logic        a_response_valid;
  logic        a_error;
  logic [15:0] a_output_data;
  logic        b_request = 1'b0;
  logic        b_write = 1'b0;
  logic        b_select_byte = 1'b0;
  logic [15:0] b_address = '0;
  logic [15:0] b_input_data = '0;
  logic        b_ready;
  logic        b_response_valid;
  logic        b_error;
  logic [15:0] b_output_data;
  logic        mem_write;
  logic        mem_select_byte;
  logic [15:0] mem_address;
  logic [15:0] mem_input_data;
  logic [15:0] mem_output_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [15:0] data;
  } resp_t;

  resp_t qa[$];
  resp_t qb[$];
  int    ia = 0;
  int    ib = 0;

  logic [7:0] ram [0:7];
  logic [7:0] ref_mem [0:7];

  memory_arbiter dut (
    .clock(clock),
    .reset(reset),
    .a_request(a_request),
    .a_write(a_write),
    .a_select_byte(a_select_byte),
    .a_address(a_address),
    .a_input_data(a_input_data),
    .a_ready(a_ready),
    .a_response_valid(a_response_valid),
    .a_error(a_error),
    .a_output_data(a_output_data),
    .b_request(b_request),
    .b_write(b_write),
    .b_select_byte(b_select_byte),
    .b_address(b_address),
    .b_input_data(b_input_data),
    .b_ready(b_ready),
    .b_response_valid(b_response_valid),
    .b_error(b_error),
    .b_output_data(b_output_data),
    .mem_write(mem_write),
    .mem_select_byte(mem_select_byte),
    .mem_address(mem_address),
    .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // memory_unit stand-in: combinational read, write on clock edge
  always @(posedge clock)
    if (mem_write) begin
      if (mem_select_byte) begin
        ram[mem_address[2:0]] <= mem_input_data[7:0];
      end else begin
        ram[{mem_address[2:1], 1'b0}] <= mem_input_data[7:0];
        ram[{mem_address[2:1], 1'b1}] <= mem_input_data[15:8];
      end
    end

  always_comb begin
    mem_output_data = '0;
    if (mem_select_byte)
      mem_output_data = {8'h00, ram[mem_address[2:0]]};
    else
      mem_output_data = {ram[{mem_address[2:1], 1'b1}],
                         ram[{mem_address[2:1], 1'b0}]};
  end

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] ad,
                                           input logic sel);
    logic [2:0] lo;
    logic [2:0] hi;
    lo = {ad[2:1], 1'b0};
    hi = {ad[2:1], 1'b1};
    if (sel) return {8'h00, ref_mem[ad[2:0]]};
    return {ref_mem[hi], ref_mem[lo]};
  endfunction

  // Reference model: grant rule, one-cycle access, response next cycle
  logic        m_busy;
  logic        m_last_b;
  logic        m_own_b;
  logic        m_wr;
  logic        m_sel;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  logic [15:0] m_out_a;
  logic [15:0] m_out_b;

  initial begin
    logic  ea;
    logic  eb;
    logic  inr;
    resp_t r;
    m_busy = 1'b0;
    m_last_b = 1'b1;
    m_own_b = 1'b0;
    m_wr = 1'b0;
    m_sel = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_out_a = '0;
    m_out_b = '0;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_busy = 1'b0;
        m_last_b = 1'b1;
        m_wr = 1'b0;
        m_sel = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_out_a = '0;
        m_out_b = '0;
        chk1("rst_a_ready", a_ready, 1'b0);
        chk1("rst_b_ready", b_ready, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_a_valid", a_response_valid, 1'b0);
        chk1("rst_b_valid", b_response_valid, 1'b0);
        chk1("rst_a_error", a_error, 1'b0);
        chk16("rst_a_data", a_output_data, 16'h0000);
        chk16("rst_b_data", b_output_data, 16'h0000);
        chk16("rst_mem_addr", mem_address, 16'h0000);
      end else begin
        ea = !m_busy && a_request && (!b_request || m_last_b);
        eb = !m_busy && b_request && (!a_request || !m_last_b);
        inr = m_addr < 16'(MB);
        chk1("a_ready", a_ready, ea);
        chk1("b_ready", b_ready, eb);
        chk1("mem_write", mem_write, m_busy && m_wr && inr);
        chk16("mem_address", mem_address, m_addr);
        chk1("mem_select_byte", mem_select_byte, m_sel);
        chk16("mem_input_data", mem_input_data, m_data);
        if (m_busy) begin
          if (m_wr && inr) begin
            if (m_sel) begin
              ref_mem[m_addr[2:0]] = m_data[7:0];
            end else begin
              ref_mem[{m_addr[2:1], 1'b0}] = m_data[7:0];
              ref_mem[{m_addr[2:1], 1'b1}] = m_data[15:8];
            end
          end
          r.due = cyc + 1;
          r.err = !inr;
          if (!m_wr && inr) begin
            if (m_own_b) m_out_b = ref_read(m_addr, m_sel);
            else         m_out_a = ref_read(m_addr, m_sel);
          end
          r.data = m_own_b ? m_out_b : m_out_a;
          if (m_own_b) qb.push_back(r);
          else         qa.push_back(r);
          m_busy = 1'b0;
        end else if (ea || eb) begin
          m_busy = 1'b1;
          m_own_b = eb;
          m_last_b = eb;
          m_wr = eb ? b_write : a_write;
          m_sel = eb ? b_select_byte : a_select_byte;
          m_addr = eb ? b_address : a_address;
          m_data = eb ? b_input_data : a_input_data;
        end
      end
    end
  end

  // Monitor: consumes expected responses as the DUT presents them
  initial begin
    resp_t r;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (a_response_valid) begin
          if (ia >= qa.size()) begin
            chk1("a_spurious_resp", a_response_valid, 1'b0);
          end else begin
            r = qa[ia];
            ia++;
            chki("a_resp_cycle", cyc, r.due);
            chk1("a_error", a_error, r.err);
            chk16("a_output_data", a_output_data, r.data);
          end
        end
        if (b_response_valid) begin
          if (ib >= qb.size()) begin
            chk1("b_spurious_resp", b_response_valid, 1'b0);
          end else begin
            r = qb[ib];
            ib++;
            chki("b_resp_cycle", cyc, r.due);
            chk1("b_error", b_error, r.err);
            chk16("b_output_data", b_output_data, r.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic txn_a(input logic w, input logic s,
                       input logic [15:0] ad, input logic [15:0] d);
    int n;
    n = 0;
    @(posedge clock);
    #1;
    a_request = 1'b1;
    a_write = w;
    a_select_byte = s;
    a_address = ad;
    a_input_data = d;
    forever begin
      @(negedge clock);
      if (a_ready) break;
      n++;
      if (n > 50) begin
        chk1("a_accept_timeout", a_ready, 1'b1);
        break;
      end
    end
    @(posedge clock);
    #1 a_request = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic txn_b(input logic w, input logic s,
                       input logic [15:0] ad, input logic [15:0] d);
    int n;
    n = 0;
    @(posedge clock);
    #1;
    b_request = 1'b1;
    b_write = w;
    b_select_byte = s;
    b_address = ad;
    b_input_data = d;
    forever begin
      @(negedge clock);
      if (b_ready) break;
      n++;
      if (n > 50) begin
        chk1("b_accept_timeout", b_ready, 1'b1);
        break;
      end
    end
    @(posedge clock);
    #1 b_request = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(9) == 0) return 16'($urandom);
    return 16'($urandom_range(11));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a_acc;
    logic b_acc;
    int   wait_n;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;

    txn_a(1'b1, 1'b0, 16'h0000, 16'h1111);
    txn_a(1'b1, 1'b0, 16'h0002, 16'h2222);
    txn_a(1'b1, 1'b0, 16'h0004, 16'h4444);
    txn_a(1'b1, 1'b0, 16'h0006, 16'h6666);

    // A word write with cycle-exact latency, then read back
    @(posedge clock);
    #1;
    a_request = 1'b1;
    a_write = 1'b1;
    a_select_byte = 1'b0;
    a_address = 16'h0002;
    a_input_data = 16'hBEEF;
    @(negedge clock);
    chk1("t1_c0_ready", a_ready, 1'b1);
    chk1("t1_c0_mem_write", mem_write, 1'b0);
    @(posedge clock);
    #1 a_request = 1'b0;
    @(negedge clock);
    chk1("t1_c1_mem_write", mem_write, 1'b1);
    chk1("t1_c1_valid", a_response_valid, 1'b0);
    @(negedge clock);
    chk1("t1_c2_mem_write", mem_write, 1'b0);
    chk1("t1_c2_valid", a_response_valid, 1'b1);
    chk1("t1_c2_error", a_error, 1'b0);
    txn_a(1'b0, 1'b0, 16'h0002, 16'h0000);
    chk16("t1_read_beef", a_output_data, 16'hBEEF);

    // B byte write merges into the word
    txn_b(1'b1, 1'b0, 16'h0004, 16'hAAAA);
    txn_b(1'b1, 1'b1, 16'h0005, 16'h0012);
    txn_b(1'b0, 1'b0, 16'h0004, 16'h0000);
    chk16("t2_merge", b_output_data, 16'h12AA);

    // Both requesting from reset: alternate grants every 2 cycles
    do_reset();
    @(posedge clock);
    #1;
    a_request = 1'b1;
    a_write = 1'b0;
    a_select_byte = 1'b0;
    a_address = 16'h0000;
    b_request = 1'b1;
    b_write = 1'b0;
    b_select_byte = 1'b0;
    b_address = 16'h0006;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk1("t3_a_grant", a_ready, (i % 4) == 0);
      chk1("t3_b_grant", b_ready, (i % 4) == 2);
    end
    @(posedge clock);
    #1;
    a_request = 1'b0;
    b_request = 1'b0;
    repeat (3) @(posedge clock);
    chk16("t3_a_data", a_output_data, 16'h1111);
    chk16("t3_b_data", b_output_data, 16'h6666);

    // Out of range: error, no write, data held
    txn_a(1'b0, 1'b0, 16'h0008, 16'h0000);
    txn_a(1'b1, 1'b0, 16'h0010, 16'h5A5A);
    chk16("t4_data_held", a_output_data, 16'h1111);

    // Reset in the middle of a write access
    @(posedge clock);
    #1;
    a_request = 1'b1;
    a_write = 1'b1;
    a_select_byte = 1'b0;
    a_address = 16'h0000;
    a_input_data = 16'h5555;
    @(negedge clock);
    chk1("t5_ready", a_ready, 1'b1);
    @(posedge clock);
    #1 a_request = 1'b0;
    #1 chk1("t5_write_in_access", mem_write, 1'b1);
    reset = 1'b1;
    #1 chk1("t5_write_dropped", mem_write, 1'b0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    txn_a(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk16("t5_prior_kept", a_output_data, 16'h1111);

    // B streaming, A asks once and must get the next free slot
    @(posedge clock);
    #1;
    b_request = 1'b1;
    b_write = 1'b0;
    b_select_byte = 1'b0;
    b_address = 16'h0006;
    repeat (3) @(posedge clock);
    #1;
    a_request = 1'b1;
    a_write = 1'b0;
    a_select_byte = 1'b0;
    a_address = 16'h0002;
    wait_n = 0;
    forever begin
      @(negedge clock);
      wait_n++;
      if (a_ready || wait_n > 10) break;
    end
    chk1("t6_a_prompt", wait_n <= 3, 1'b1);
    @(posedge clock);
    #1 a_request = 1'b0;
    repeat (4) @(posedge clock);
    #1 b_request = 1'b0;
    repeat (3) @(posedge clock);
    chk16("t6_a_data", a_output_data, 16'hBEEF);
    chk16("t6_b_data", b_output_data, 16'h6666);

    // Randomized traffic from both requesters
    a_acc = 1'b0;
    b_acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clock);
      #1;
      if (a_request && (a_acc || $urandom_range(15) == 0)) begin
        a_request = 1'b0;
      end else if (!a_request && $urandom_range(1) == 1) begin
        a_request = 1'b1;
        a_write = 1'($urandom_range(1));
        a_select_byte = 1'($urandom_range(1));
        a_address = rand_addr();
        a_input_data = 16'($urandom);
      end
      if (b_request && (b_acc || $urandom_range(15) == 0)) begin
        b_request = 1'b0;
      end else if (!b_request && $urandom_range(1) == 1) begin
        b_request = 1'b1;
        b_write = 1'($urandom_range(1));
        b_select_byte = 1'($urandom_range(1));
        b_address = rand_addr();
        b_input_data = 16'($urandom);
      end
      @(negedge clock);
      a_acc = a_ready;
      b_acc = b_ready;
    end
    @(posedge clock);
    #1;
    a_request = 1'b0;
    b_request = 1'b0;
    repeat (4) @(posedge clock);
    chki("a_all_responded", ia, qa.size());
    chki("b_all_responded", ib, qb.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
